// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline-stage register: 2-entry skid buffer, registered in_ready, synchronous flush.
// Define PIPE_STAGE_PERF_EN to add the saturating stall_cycles counter port.
module pipe_stage_elastic #(
   parameter int               WIDTH          = 16,
   parameter logic [WIDTH-1:0] RESET_VAL      = '0,
   parameter bit               CLEAR_ON_FLUSH = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       occupancy
`ifdef PIPE_STAGE_PERF_EN
   ,output logic [15:0]     stall_cycles
`endif
);

   // Handshake: a payload moves on any rising edge where valid and ready are both 1;
   // valid never depends on ready, and in_ready is a pure flop output.
   // Encoding puts main_v in bit 0 and skid_v in bit 1 so both come straight off flops.
   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      ONE   = 2'b01,
      FULL  = 2'b11
   } state_t;

   state_t           state_q, state_d;
   logic             main_v, skid_v;
   logic [WIDTH-1:0] main_d, skid_d;
   logic             accept, emit;
   logic             main_ld, main_from_skid, skid_ld;

   assign main_v    = state_q[0];
   assign skid_v    = state_q[1];
   assign in_ready  = ~skid_v;
   assign out_valid = main_v;
   assign out_data  = main_d;
   assign occupancy = {1'b0, main_v} + {1'b0, skid_v};
   assign accept    = in_valid & in_ready;
   assign emit      = out_valid & out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= EMPTY;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d        = state_q;
      main_ld        = 1'b0;
      main_from_skid = 1'b0;
      skid_ld        = 1'b0;
      case (state_q)
         EMPTY: begin
            if (accept) begin
               state_d = ONE;
               main_ld = 1'b1;
            end
         end
         ONE: begin
            if (accept && emit) begin
               main_ld = 1'b1;
            end else if (accept) begin
               state_d = FULL;
               skid_ld = 1'b1;
            end else if (emit) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            if (emit) begin
               state_d        = ONE;
               main_ld        = 1'b1;
               main_from_skid = 1'b1;
            end
         end
         default: state_d = EMPTY;
      endcase
      // Flush wins over everything, including a same-cycle accept.
      if (flush) begin
         state_d = EMPTY;
         main_ld = 1'b0;
         skid_ld = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_d <= RESET_VAL;
         skid_d <= RESET_VAL;
      end else if (flush) begin
         if (CLEAR_ON_FLUSH) begin
            main_d <= RESET_VAL;
            skid_d <= RESET_VAL;
         end
      end else begin
         if (main_ld) main_d <= main_from_skid ? skid_d : in_data;
         if (skid_ld) skid_d <= in_data;
      end
   end

`ifdef PIPE_STAGE_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         stall_cycles <= '0;
      else if (out_valid && !out_ready && stall_cycles != 16'hFFFF)
         stall_cycles <= stall_cycles + 16'd1;
   end
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: directed scenarios plus random traffic against a FIFO-queue model.
// Build with PIPE_STAGE_PERF_EN defined to also exercise stall_cycles.
module tb_pipe_stage_elastic;

   localparam int          W    = 16;
   localparam logic [W-1:0] RVAL = 16'h0000;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] in_data = '0;
   logic         flush = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] out_data;
   logic [1:0]   occupancy;
`ifdef PIPE_STAGE_PERF_EN
   logic [15:0]  stall_cycles;
   int           stall_exp = 0;
`endif

   int checks = 0;
   int errors = 0;

   // Model: payloads accepted but not yet emitted, oldest first.
   logic [W-1:0] exp_q[$];
   logic [W-1:0] idle_exp = RVAL;

   pipe_stage_elastic #(.WIDTH(W), .RESET_VAL(RVAL), .CLEAR_ON_FLUSH(1'b1)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .occupancy(occupancy)
`ifdef PIPE_STAGE_PERF_EN
      ,.stall_cycles(stall_cycles)
`endif
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // driver tasks
   task automatic drive(input logic v, input logic [W-1:0] d, input logic ordy, input logic fl);
      in_valid  = v;
      in_data   = d;
      out_ready = ordy;
      flush     = fl;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input logic ordy, input int n);
      for (int i = 0; i < n; i++) drive(1'b0, '0, ordy, 1'b0);
   endtask

   // scoreboard / monitor: checks then advances the model for the coming edge
   always @(negedge clk) begin
      int          n;
      logic [W-1:0] head;
      if (!rst_n) begin
         chk("rst_out_valid", out_valid, 0);
         chk("rst_in_ready", in_ready, 1);
         chk("rst_occupancy", occupancy, 0);
         chk("rst_out_data", out_data, RVAL);
`ifdef PIPE_STAGE_PERF_EN
         chk("rst_stall_cycles", stall_cycles, 0);
         stall_exp = 0;
`endif
         exp_q.delete();
         idle_exp = RVAL;
      end else begin
         n = exp_q.size();
         chk("occupancy", occupancy, n);
         chk("in_ready", in_ready, (n < 2) ? 1 : 0);
         chk("out_valid", out_valid, (n > 0) ? 1 : 0);
         if (n > 0) chk("out_data", out_data, exp_q[0]);
         else       chk("out_data_idle", out_data, idle_exp);
`ifdef PIPE_STAGE_PERF_EN
         chk("stall_cycles", stall_cycles, stall_exp);
         if (n > 0 && !out_ready && stall_exp < 16'hFFFF) stall_exp++;
`endif
         if (n > 0 && out_ready) begin
            head = exp_q.pop_front();
            if (exp_q.size() == 0) idle_exp = head;
         end
         if (flush) begin
            exp_q.delete();
            idle_exp = RVAL;
         end else if (in_valid && n < 2) begin
            exp_q.push_back(in_data);
         end
      end
   end

   initial begin
      // Reset with a payload waiting upstream; it must land one cycle after release.
      rst_n = 1'b0;
      in_valid = 1'b1;
      in_data = 16'h1234;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      drive(1'b1, 16'h1234, 1'b0, 1'b0);
      idle(1'b0, 2);
      idle(1'b1, 2);

      // Streaming at full rate.
      for (int i = 1; i <= 8; i++) drive(1'b1, W'(i), 1'b1, 1'b0);
      idle(1'b1, 3);

      // Backpressure fills the skid, then drains in order.
      drive(1'b1, 16'hAAAA, 1'b0, 1'b0);
      drive(1'b1, 16'hBBBB, 1'b0, 1'b0);
      drive(1'b1, 16'hCCCC, 1'b0, 1'b0);
      idle(1'b0, 2);
      idle(1'b1, 3);

      // Simultaneous accept and emit in ONE.
      drive(1'b1, 16'h0101, 1'b0, 1'b0);
      drive(1'b1, 16'h0202, 1'b1, 1'b0);
      idle(1'b0, 2);
      idle(1'b1, 2);

      // Flush in FULL with a competing accept.
      drive(1'b1, 16'h1111, 1'b0, 1'b0);
      drive(1'b1, 16'h2222, 1'b0, 1'b0);
      drive(1'b1, 16'h3333, 1'b0, 1'b1);
      idle(1'b1, 3);

      // Reset asserted mid-cycle must drop the entry without a clock edge.
      drive(1'b1, 16'h5555, 1'b0, 1'b0);
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_out_valid", out_valid, 0);
      chk("async_rst_occupancy", occupancy, 0);
      chk("async_rst_out_data", out_data, RVAL);
      @(posedge clk);
      #1 rst_n = 1'b1;
      idle(1'b1, 2);

      // Random traffic with occasional flushes.
      for (int i = 0; i < 3000; i++)
         drive(1'(($urandom_range(0, 3)) != 0), W'($urandom),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 40) == 0));
      idle(1'b1, 5);

`ifdef PIPE_STAGE_PERF_EN
      // Saturation, flush immunity, then reset clear.
      drive(1'b1, 16'h7777, 1'b0, 1'b0);
      idle(1'b0, 70000);
      chk("stall_saturated", stall_cycles, 16'hFFFF);
      drive(1'b0, '0, 1'b0, 1'b1);
      chk("stall_after_flush", stall_cycles, 16'hFFFF);
      #2 rst_n = 1'b0;
      #1 chk("stall_after_reset", stall_cycles, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      idle(1'b1, 2);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
